exc_commit_ctrl: RTL and testbench

- Commit-point exception/interrupt sequencer between the writeback stage and the CP0 register file.
- Samples the retiring instruction and arbitrates between an external interrupt, its own exception flags, ERET and normal commit.
- Drives the one-hot exc_type/eret strobes into CP0, then runs a flush → redirect sequence with a valid/ready handshake to fetch.
- Enforces an interrupt hold-off window after MTC0/ERET.

---
 rtl/exc_commit_ctrl_pkg.sv | 30 +++
 rtl/exc_prio_enc.sv | 32 +++
 rtl/exc_commit_ctrl.sv | 131 +++++++++++++
 tb/tb_exc_commit_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the commit-point exception sequencer.
// Holds the exc_type one-hot bits, wb_exc flag indices, vector and FSM states.
package exc_commit_ctrl_pkg;

  localparam int INT_BIT  = 7;
  localparam int RINE_BIT = 6;
  localparam int RDAE_BIT = 5;
  localparam int ADES_BIT = 4;
  localparam int SYS_BIT  = 3;
  localparam int BP_BIT   = 2;
  localparam int RI_BIT   = 1;
  localparam int OV_BIT   = 0;

  localparam int WB_ADEL_IF = 6;
  localparam int WB_RI      = 5;
  localparam int WB_SYS     = 4;
  localparam int WB_BP      = 3;
  localparam int WB_OV      = 2;
  localparam int WB_ADEL_LD = 1;
  localparam int WB_ADES    = 0;

  localparam logic [31:0] EXCVEC_BEV1 = 32'hBFC00380;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Exception flag priority encoder: 7 raw flags to one-hot exc_type.
// Purely combinational; also used by the decode-stage exception merge.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic [6:0] flags,
  output logic [7:0] onehot,
  output logic       any
);

  // Fetch faults outrank everything the instruction itself could raise.
  always_comb begin
    onehot = '0;
    if (flags[WB_ADEL_IF])
      onehot[RINE_BIT] = 1'b1;
    else if (flags[WB_RI])
      onehot[RI_BIT] = 1'b1;
    else if (flags[WB_SYS])
      onehot[SYS_BIT] = 1'b1;
    else if (flags[WB_BP])
      onehot[BP_BIT] = 1'b1;
    else if (flags[WB_OV])
      onehot[OV_BIT] = 1'b1;
    else if (flags[WB_ADEL_LD])
      onehot[RDAE_BIT] = 1'b1;
    else if (flags[WB_ADES])
      onehot[ADES_BIT] = 1'b1;
  end

  assign any = |flags;

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-point sequencer: arbitrates interrupt/exception/ERET/commit,
// strobes CP0, then flushes and redirects fetch via valid/ready.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXCVEC_BEV1,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          INT_HOLDOFF  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_is_slot,
  input  logic [6:0]  wb_exc,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_eret,
  input  logic        wb_mtc0,
  input  logic        int_happen,
  input  logic [31:0] cp0_epc,
  output logic [7:0]  exc_type,
  output logic [31:0] exc_pc,
  output logic        exc_is_slot,
  output logic [31:0] exc_badvaddr,
  output logic        eret_out,
  output logic        commit_ok,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic [3:0] HOLD_LD  = 4'(INT_HOLDOFF);

  state_t      state, state_nx;
  logic [3:0]  fcnt, fcnt_nx;
  logic [3:0]  hcnt, hcnt_nx;
  logic [31:0] target, target_nx;

  logic [7:0]  enc_type;
  logic        exc_any;
  logic        int_ok;

  exc_prio_enc u_enc (
    .flags  (wb_exc),
    .onehot (enc_type),
    .any    (exc_any)
  );

  assign int_ok = int_happen && (hcnt == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      fcnt   <= '0;
      hcnt   <= '0;
      target <= '0;
    end else begin
      state  <= state_nx;
      fcnt   <= fcnt_nx;
      hcnt   <= hcnt_nx;
      target <= target_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    fcnt_nx        = fcnt;
    hcnt_nx        = hcnt;
    target_nx      = target;
    exc_type       = '0;
    exc_pc         = '0;
    exc_is_slot    = 1'b0;
    exc_badvaddr   = '0;
    eret_out       = 1'b0;
    commit_ok      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state)
      S_IDLE: begin
        // Hold-off counts commit opportunities, so it only runs in IDLE.
        if (hcnt != 4'd0)
          hcnt_nx = hcnt - 4'd1;
        if (wb_valid) begin
          if (int_ok || exc_any) begin
            exc_type    = int_ok ? 8'h80 : enc_type;
            exc_pc      = wb_pc;
            exc_is_slot = wb_is_slot;
            if (!int_ok && enc_type[RINE_BIT])
              exc_badvaddr = wb_pc;
            else
              exc_badvaddr = wb_badvaddr;
            target_nx = EXC_VECTOR;
            fcnt_nx   = FLUSH_LD;
            state_nx  = S_FLUSH;
          end else if (wb_eret) begin
            eret_out  = 1'b1;
            hcnt_nx   = HOLD_LD;
            target_nx = cp0_epc;
            fcnt_nx   = FLUSH_LD;
            state_nx  = S_FLUSH;
          end else begin
            commit_ok = 1'b1;
            if (wb_mtc0)
              hcnt_nx = HOLD_LD;
          end
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (fcnt <= 4'd1)
          state_nx = S_REDIRECT;
        else
          fcnt_nx = fcnt - 4'd1;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
        if (redirect_ready)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl.
// Each task drives one scenario and checks hand-computed values inline.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_is_slot;
  logic [6:0]  wb_exc;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic        wb_mtc0;
  logic        int_happen;
  logic [31:0] cp0_epc;
  logic [7:0]  exc_type;
  logic [31:0] exc_pc;
  logic        exc_is_slot;
  logic [31:0] exc_badvaddr;
  logic        eret_out;
  logic        commit_ok;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_is_slot     (wb_is_slot),
    .wb_exc         (wb_exc),
    .wb_badvaddr    (wb_badvaddr),
    .wb_eret        (wb_eret),
    .wb_mtc0        (wb_mtc0),
    .int_happen     (int_happen),
    .cp0_epc        (cp0_epc),
    .exc_type       (exc_type),
    .exc_pc         (exc_pc),
    .exc_is_slot    (exc_is_slot),
    .exc_badvaddr   (exc_badvaddr),
    .eret_out       (eret_out),
    .commit_ok      (commit_ok),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .busy           (busy)
  );

  task automatic clear_wb();
    wb_valid    = 1'b0;
    wb_pc       = '0;
    wb_is_slot  = 1'b0;
    wb_exc      = '0;
    wb_badvaddr = '0;
    wb_eret     = 1'b0;
    wb_mtc0     = 1'b0;
    int_happen  = 1'b0;
  endtask

  // Moves past a taken exception/ERET back to IDLE; ok=0 on timeout.
  task automatic drain(output bit ok);
    @(posedge clk); #1;
    clear_wb();
    redirect_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_wb();
    cp0_epc = '0;
    redirect_ready = 1'b0;
    #3;
    total_cnt++;
    if ({busy, flush, redirect_valid, commit_ok, eret_out} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000",
               {busy, flush, redirect_valid, commit_ok, eret_out});
    else pass_cnt++;
    total_cnt++;
    if (exc_type !== 8'h00 || redirect_pc !== 32'h0)
      $display("FAIL reset_data got %h/%h want 00/0", exc_type, redirect_pc);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_commit();
    @(negedge clk);
    wb_valid = 1'b1;
    wb_pc = 32'hBFC00010;
    #2;
    total_cnt++;
    if ({commit_ok, flush, busy, eret_out} !== 4'b1000 || exc_type !== 8'h00)
      $display("FAIL commit got ok/fl/busy/eret=%b type=%h want 1000/00",
               {commit_ok, flush, busy, eret_out}, exc_type);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL commit_busy got %b want 0", busy);
    else pass_cnt++;
    @(negedge clk);
    clear_wb();
  endtask

  task automatic test_overflow();
    int n;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_exc = 7'b0000100;
    wb_pc = 32'hBFC00100;
    wb_is_slot = 1'b1;
    wb_badvaddr = 32'h00001234;
    #2;
    total_cnt++;
    if (exc_type !== 8'h01 || exc_pc !== 32'hBFC00100 || exc_is_slot !== 1'b1)
      $display("FAIL ov_strobe got %h/%h/%b want 01/bfc00100/1",
               exc_type, exc_pc, exc_is_slot);
    else pass_cnt++;
    total_cnt++;
    if (exc_badvaddr !== 32'h00001234 || commit_ok !== 1'b0)
      $display("FAIL ov_badv got %h/%b want 00001234/0", exc_badvaddr, commit_ok);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (exc_type !== 8'h00 || busy !== 1'b1)
      $display("FAIL ov_one_cycle got type=%h busy=%b want 00/1", exc_type, busy);
    else pass_cnt++;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (redirect_valid) break;
      if (flush) n++;
    end
    total_cnt++;
    if (n !== 2 || redirect_valid !== 1'b1 || flush !== 1'b0)
      $display("FAIL ov_flush got n=%0d rv=%b fl=%b want 2/1/0",
               n, redirect_valid, flush);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC00380)
        $display("FAIL ov_hold got %b/%h want 1/bfc00380",
                 redirect_valid, redirect_pc);
      else pass_cnt++;
    end
    clear_wb();
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL ov_done got busy=%b rv=%b want 0/0", busy, redirect_valid);
    else pass_cnt++;
  endtask

  task automatic test_int_vs_exc();
    bit ok;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_exc = 7'b0010000;
    int_happen = 1'b1;
    wb_pc = 32'h80001000;
    wb_badvaddr = 32'h0000BEEF;
    #2;
    total_cnt++;
    if (exc_type !== 8'h80 || exc_badvaddr !== 32'h0000BEEF)
      $display("FAIL int_vs_sys got %h/%h want 80/0000beef",
               exc_type, exc_badvaddr);
    else pass_cnt++;
    drain(ok);
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL int_drain got %b want 1", ok);
    else pass_cnt++;
  endtask

  task automatic test_eret();
    bit ok;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_eret = 1'b1;
    cp0_epc = 32'hBFC01234;
    #2;
    total_cnt++;
    if (eret_out !== 1'b1 || commit_ok !== 1'b0 || exc_type !== 8'h00)
      $display("FAIL eret_strobe got %b/%b/%h want 1/0/00",
               eret_out, commit_ok, exc_type);
    else pass_cnt++;
    @(posedge clk); #1;
    cp0_epc = 32'hDEAD0000;
    clear_wb();
    total_cnt++;
    if (eret_out !== 1'b0)
      $display("FAIL eret_one_cycle got %b want 0", eret_out);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (redirect_valid) break;
    end
    total_cnt++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC01234)
      $display("FAIL eret_target got %b/%h want 1/bfc01234",
               redirect_valid, redirect_pc);
    else pass_cnt++;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    wb_valid = 1'b1;
    int_happen = 1'b1;
    #2;
    total_cnt++;
    if (busy !== 1'b0 || commit_ok !== 1'b1 || exc_type !== 8'h00)
      $display("FAIL holdoff_c1 got busy=%b ok=%b type=%h want 0/1/00",
               busy, commit_ok, exc_type);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (commit_ok !== 1'b1 || exc_type !== 8'h00)
      $display("FAIL holdoff_c2 got ok=%b type=%h want 1/00", commit_ok, exc_type);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (commit_ok !== 1'b0 || exc_type !== 8'h80)
      $display("FAIL holdoff_c3 got ok=%b type=%h want 0/80", commit_ok, exc_type);
    else pass_cnt++;
    drain(ok);
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL eret_drain got %b want 1", ok);
    else pass_cnt++;
  endtask

  task automatic test_mtc0_holdoff();
    @(negedge clk);
    wb_valid = 1'b1;
    wb_mtc0 = 1'b1;
    #2;
    total_cnt++;
    if (commit_ok !== 1'b1)
      $display("FAIL mtc0_commit got %b want 1", commit_ok);
    else pass_cnt++;
    @(posedge clk); #1;
    wb_mtc0 = 1'b0;
    int_happen = 1'b1;
    #2;
    total_cnt++;
    if (commit_ok !== 1'b1 || exc_type !== 8'h00)
      $display("FAIL mtc0_mask got ok=%b type=%h want 1/00", commit_ok, exc_type);
    else pass_cnt++;
    @(negedge clk);
    clear_wb();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_no_valid();
    @(negedge clk);
    wb_valid = 1'b0;
    int_happen = 1'b1;
    wb_exc = 7'b0000100;
    #2;
    total_cnt++;
    if (exc_type !== 8'h00 || commit_ok !== 1'b0 || eret_out !== 1'b0)
      $display("FAIL novalid got %h/%b/%b want 00/0/0",
               exc_type, commit_ok, eret_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL novalid_busy got %b want 0", busy);
    else pass_cnt++;
    @(negedge clk);
    clear_wb();
  endtask

  task automatic test_fetch_fault();
    bit ok;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_exc = 7'b1000000;
    wb_eret = 1'b1;
    wb_pc = 32'h80000003;
    wb_badvaddr = 32'h11111111;
    #2;
    total_cnt++;
    if (exc_type !== 8'h40 || exc_badvaddr !== 32'h80000003)
      $display("FAIL adel_if got %h/%h want 40/80000003", exc_type, exc_badvaddr);
    else pass_cnt++;
    total_cnt++;
    if (eret_out !== 1'b0 || exc_pc !== 32'h80000003)
      $display("FAIL adel_if_eret got %b/%h want 0/80000003", eret_out, exc_pc);
    else pass_cnt++;
    drain(ok);
    total_cnt++;
    if (ok !== 1'b1)
      $display("FAIL adel_if_drain got %b want 1", ok);
    else pass_cnt++;
  endtask

  task automatic test_reset_redirect();
    @(negedge clk);
    wb_valid = 1'b1;
    wb_exc = 7'b0000001;
    @(posedge clk); #1;
    clear_wb();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (redirect_valid) break;
    end
    total_cnt++;
    if (redirect_valid !== 1'b1)
      $display("FAIL rst_pre got rv=%b want 1", redirect_valid);
    else pass_cnt++;
    #2;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if ({redirect_valid, busy, flush} !== 3'b000)
      $display("FAIL rst_async got %b want 000", {redirect_valid, busy, flush});
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_overflow();
    test_int_vs_exc();
    test_eret();
    test_mtc0_holdoff();
    test_no_valid();
    test_fetch_fault();
    test_reset_redirect();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
